// File: rtl/coin_sampler_if.sv
// Coin-slot sensor inputs and conditioned coin code outputs.
// No backpressure: the consumer samples coin on every edge.
interface coin_sampler_if;
   logic       key_half_n;
   logic       key_one_n;
   logic [1:0] coin;
   logic [7:0] coin_cnt;

   modport master (output key_half_n, output key_one_n, input coin, input coin_cnt);
   modport slave  (input key_half_n, input key_one_n, output coin, output coin_cnt);
endinterface

// File: rtl/coin_sampler.sv
// Sync + debounce two coin sensors into serialised one-cycle coin codes; latency 3+CNT_MAX edges.
// No backpressure: simultaneous coins are queued one deep per channel and emitted back to back.
module coin_sampler #(
   parameter int CNT_MAX = 1_000_000,
   parameter int CNT_W   = 20
) (
   input  logic           clk,
   input  logic           rst,
   coin_sampler_if.slave  bus
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

   // Channel index 0 = half yuan, 1 = one yuan.
   logic [1:0]       raw;
   logic [1:0]       s1;
   logic [1:0]       s2;
   logic [1:0]       stable;
   logic [1:0]       stable_d;
   logic [1:0]       press;
   logic [CNT_W-1:0] dbc_cnt [2];

   logic [1:0]       coin_q;
   logic [1:0]       coin_nxt;
   logic [7:0]       coin_cnt_q;
   logic             pend_one;
   logic             pend_one_nxt;
   logic             pend_half;
   logic             pend_half_nxt;

   assign raw = {bus.key_one_n, bus.key_half_n};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1         <= 2'b11;
         s2         <= 2'b11;
         stable     <= 2'b11;
         stable_d   <= 2'b11;
         dbc_cnt[0] <= '0;
         dbc_cnt[1] <= '0;
      end else begin
         s1       <= raw;
         s2       <= s1;
         stable_d <= stable;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == stable[i]) begin
               dbc_cnt[i] <= '0;
            end else if (dbc_cnt[i] == CNT_LAST) begin
               stable[i]  <= s2[i];
               dbc_cnt[i] <= '0;
            end else begin
               dbc_cnt[i] <= dbc_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Only the falling edge of the debounced level is a coin.
   assign press = stable_d & ~stable;

   always_comb begin
      coin_nxt      = 2'd0;
      pend_one_nxt  = pend_one;
      pend_half_nxt = pend_half;
      if (pend_one) begin
         coin_nxt     = 2'd2;
         pend_one_nxt = 1'b0;
         if (press[0]) pend_half_nxt = 1'b1;
      end else if (pend_half) begin
         coin_nxt      = 2'd1;
         pend_half_nxt = press[0];
         if (press[1]) pend_one_nxt = 1'b1;
      end else if (press[0] && press[1]) begin
         coin_nxt     = 2'd1;
         pend_one_nxt = 1'b1;
      end else if (press[0]) begin
         coin_nxt = 2'd1;
      end else if (press[1]) begin
         coin_nxt = 2'd2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         coin_q     <= 2'd0;
         coin_cnt_q <= 8'd0;
         pend_one   <= 1'b0;
         pend_half  <= 1'b0;
      end else begin
         coin_q    <= coin_nxt;
         pend_one  <= pend_one_nxt;
         pend_half <= pend_half_nxt;
         if (coin_nxt != 2'd0) coin_cnt_q <= coin_cnt_q + 8'd1;
      end
   end

   assign bus.coin     = coin_q;
   assign bus.coin_cnt = coin_cnt_q;
endmodule

// File: tb/tb_coin_sampler.sv
// Randomised and directed bench for coin_sampler against a window/queue model.
module tb_coin_sampler;
   localparam int TB_CNT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic chk_en = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   coin_sampler_if bus();

   coin_sampler #(.CNT_MAX(TB_CNT), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: a press is a debounced level falling after TB_CNT identical
   // synchronised samples; coins leave a FIFO at one per cycle.
   logic              r1 [2];
   logic              r2 [2];
   logic              stab [2];
   logic [TB_CNT-1:0] win [2];
   int                coin_q[$];
   int                exp_coin = 0;
   logic [7:0]        exp_cnt = 8'd0;

   always @(posedge clk) begin
      logic seen;
      logic cur [2];
      cur[0] = bus.key_half_n;
      cur[1] = bus.key_one_n;
      if (rst) begin
         exp_coin = 0;
         exp_cnt  = 8'd0;
         coin_q.delete();
         for (int c = 0; c < 2; c++) begin
            r1[c] = 1'b1; r2[c] = 1'b1; stab[c] = 1'b1; win[c] = '1;
         end
      end else begin
         exp_coin = (coin_q.size() > 0) ? coin_q.pop_front() : 0;
         if (exp_coin != 0) exp_cnt = exp_cnt + 8'd1;
         for (int c = 0; c < 2; c++) begin
            seen   = r2[c];
            r2[c]  = r1[c];
            r1[c]  = cur[c];
            win[c] = {win[c][TB_CNT-2:0], seen};
            if (stab[c] && win[c] == '0) begin
               stab[c] = 1'b0;
               coin_q.push_back(c + 1);
            end else if (!stab[c] && win[c] == '1) begin
               stab[c] = 1'b1;
            end
         end
      end
      chk_en <= 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("coin", int'(bus.coin), exp_coin);
         chk("coin_cnt", int'(bus.coin_cnt), int'(exp_cnt));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int hold_h;
      int hold_o;
      bus.key_half_n = 1'b1;
      bus.key_one_n  = 1'b1;
      tick(3);
      rst = 1'b0;
      chk("reset_coin", int'(bus.coin), 0);
      chk("reset_cnt", int'(bus.coin_cnt), 0);
      tick(2);

      // Clean half press.
      bus.key_half_n = 1'b0;
      tick(6); chk("s1_early", int'(bus.coin), 0);
      tick(1); chk("s1_pulse", int'(bus.coin), 1);
      chk("s1_cnt", int'(bus.coin_cnt), 1);
      chk("s1_model", exp_coin, 1);
      tick(1); chk("s1_width", int'(bus.coin), 0);
      tick(12); bus.key_half_n = 1'b1;
      tick(10); chk("s1_release_cnt", int'(bus.coin_cnt), 1);

      // Bounce rejection, then a real press.
      for (int k = 0; k < 6; k++) begin
         bus.key_one_n = (k % 2 == 0) ? 1'b0 : 1'b1;
         tick(2);
      end
      bus.key_one_n = 1'b1;
      tick(10); chk("s2_bounce_cnt", int'(bus.coin_cnt), 1);
      bus.key_one_n = 1'b0;
      tick(7); chk("s2_pulse", int'(bus.coin), 2);
      chk("s2_cnt", int'(bus.coin_cnt), 2);
      tick(1); chk("s2_width", int'(bus.coin), 0);
      bus.key_one_n = 1'b1;
      tick(10);

      // Simultaneous insert.
      bus.key_half_n = 1'b0; bus.key_one_n = 1'b0;
      tick(7); chk("s3_first", int'(bus.coin), 1);
      tick(1); chk("s3_second", int'(bus.coin), 2);
      chk("s3_model", exp_coin, 2);
      tick(1); chk("s3_idle", int'(bus.coin), 0);
      chk("s3_cnt", int'(bus.coin_cnt), 4);
      bus.key_half_n = 1'b1; bus.key_one_n = 1'b1;
      tick(10);

      // Staggered presses one cycle apart.
      bus.key_one_n = 1'b0;
      tick(1); bus.key_half_n = 1'b0;
      tick(6); chk("s4_one", int'(bus.coin), 2);
      tick(1); chk("s4_half", int'(bus.coin), 1);
      tick(1); chk("s4_idle", int'(bus.coin), 0);
      chk("s4_cnt", int'(bus.coin_cnt), 6);
      bus.key_half_n = 1'b1; bus.key_one_n = 1'b1;
      tick(10);

      // Reset mid-debounce with key held across release.
      bus.key_half_n = 1'b0;
      tick(4); rst = 1'b1;
      tick(1); rst = 1'b0;
      chk("s5_reset_cnt", int'(bus.coin_cnt), 0);
      tick(6); chk("s5_early", int'(bus.coin), 0);
      tick(1); chk("s5_pulse", int'(bus.coin), 1);
      chk("s5_cnt", int'(bus.coin_cnt), 1);
      bus.key_half_n = 1'b1;
      tick(10);

      // Counter wrap: 256 more coins bring the count back to 1.
      for (int i = 0; i < 256; i++) begin
         if (i % 2 == 0) bus.key_half_n = 1'b0;
         else            bus.key_one_n  = 1'b0;
         tick(6);
         bus.key_half_n = 1'b1; bus.key_one_n = 1'b1;
         tick(8);
      end
      tick(10);
      chk("s6_wrap_cnt", int'(bus.coin_cnt), 1);

      // Random bouncing on both channels with occasional resets.
      hold_h = 1; hold_o = 1;
      for (int i = 0; i < 4000; i++) begin
         if (--hold_h == 0) begin
            bus.key_half_n = ~bus.key_half_n;
            hold_h = $urandom_range(1, 10);
         end
         if (--hold_o == 0) begin
            bus.key_one_n = ~bus.key_one_n;
            hold_o = $urandom_range(1, 10);
         end
         rst = ($urandom_range(0, 599) == 0);
         tick(1);
      end
      rst = 1'b0;
      bus.key_half_n = 1'b1; bus.key_one_n = 1'b1;
      tick(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
